// File: rtl/alu_pkg.sv
// Shared constants for the MIPS ALU issue stage: ALU control codes, opcode/funct values and FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_LUI = 4'b1010;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_MUL   = 6'h1C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_MUL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        MUL_WAIT = 2'd1,
        FULL     = 2'd2
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of a MIPS instruction into ALU control code and operands.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic [3:0]  o_alu_C,
    output logic [31:0] o_alu_A,
    output logic [31:0] o_alu_B,
    output logic        o_is_mul,
    output logic        o_illegal
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused_bits;

    assign w_opcode      = i_instr[31:26];
    assign w_funct       = i_instr[5:0];
    // Register specifiers are resolved upstream; only the operand values matter here.
    assign w_unused_bits = ^i_instr[25:16];

    always_comb begin
        o_alu_C   = ALU_NOP;
        o_alu_A   = '0;
        o_alu_B   = '0;
        o_is_mul  = 1'b0;
        o_illegal = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD: begin
                        o_alu_C = ALU_ADD;
                        o_alu_A = i_rs_data;
                        o_alu_B = i_rt_data;
                    end
                    FN_SUB: begin
                        o_alu_C = ALU_SUB;
                        o_alu_A = i_rs_data;
                        o_alu_B = i_rt_data;
                    end
                    FN_SRL: begin
                        o_alu_C = ALU_SRL;
                        o_alu_A = i_rt_data;
                        o_alu_B = {27'd0, i_instr[10:6]};
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_MUL: begin
                if (w_funct == FN_MUL) begin
                    o_alu_C  = ALU_MUL;
                    o_alu_A  = i_rs_data;
                    o_alu_B  = i_rt_data;
                    o_is_mul = 1'b1;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OP_LUI: begin
                o_alu_C = ALU_LUI;
                o_alu_B = {16'd0, i_instr[15:0]};
            end
            OP_ADDI, OP_LW, OP_SW: begin
                o_alu_C = ALU_ADD;
                o_alu_A = i_rs_data;
                o_alu_B = {{16{i_instr[15]}}, i_instr[15:0]};
            end
            OP_BEQ: begin
                o_alu_C = ALU_SUB;
                o_alu_A = i_rs_data;
                o_alu_B = i_rt_data;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Registered ALU issue stage with valid/ready handshake and multicycle multiply stretch.
// Optional macro ALU_ISSUE_ILLEGAL_TRAP_EN: forward illegal instructions flagged instead of dropping them.
module alu_issue
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [3:0]  alu_C,
    output logic        illegal
);

    localparam logic [3:0] MUL_LOAD    = 4'(MUL_CYCLES - 1);
    localparam bit         MUL_STRETCH = (MUL_CYCLES > 1);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam bit         TRAP_EN     = 1'b1;
`else
    localparam bit         TRAP_EN     = 1'b0;
`endif

    state_t      r_state;
    state_t      w_state_next;
    state_t      w_accept_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [31:0] r_alu_A;
    logic [31:0] r_alu_B;
    logic [3:0]  r_alu_C;
    logic [3:0]  w_dec_C;
    logic [31:0] w_dec_A;
    logic [31:0] w_dec_B;
    logic        w_dec_is_mul;
    logic        w_dec_illegal;
    logic        w_in_ready;
    logic        w_accept;

    alu_decode u_decode (
        .i_instr   (instr),
        .i_rs_data (rs_data),
        .i_rt_data (rt_data),
        .o_alu_C   (w_dec_C),
        .o_alu_A   (w_dec_A),
        .o_alu_B   (w_dec_B),
        .o_is_mul  (w_dec_is_mul),
        .o_illegal (w_dec_illegal)
    );

    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            EMPTY:   w_in_ready = 1'b1;
            FULL:    w_in_ready = out_ready;
            default: w_in_ready = 1'b0;
        endcase
        if (rst) begin
            w_in_ready = 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign w_accept  = in_valid && w_in_ready;
    assign out_valid = (r_state == FULL);

    // Where a freshly accepted instruction lands; untrapped illegals vanish without a pulse.
    always_comb begin
        w_accept_state = FULL;
        if (w_dec_illegal && !TRAP_EN) begin
            w_accept_state = EMPTY;
        end else if (w_dec_is_mul && MUL_STRETCH) begin
            w_accept_state = MUL_WAIT;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_next = w_accept_state;
                end
            end
            MUL_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = FULL;
                end
            end
            FULL: begin
                if (w_accept) begin
                    w_state_next = w_accept_state;
                end else if (out_ready) begin
                    w_state_next = EMPTY;
                end
            end
            default: w_state_next = EMPTY;
        endcase
        if (w_accept && w_dec_is_mul) begin
            w_cnt_next = MUL_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_cnt   <= '0;
            r_alu_A <= '0;
            r_alu_B <= '0;
            r_alu_C <= ALU_NOP;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_alu_A <= w_dec_A;
                r_alu_B <= w_dec_B;
                r_alu_C <= w_dec_C;
            end
        end
    end

    assign alu_A = r_alu_A;
    assign alu_B = r_alu_B;
    assign alu_C = r_alu_C;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_illegal <= w_dec_illegal;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed scoreboard bench for alu_issue (MUL_CYCLES=3); honours ALU_ISSUE_ILLEGAL_TRAP_EN when defined.
module tb_alu_issue;

    localparam int MUL_CYCLES = 3;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [3:0]  alu_C;
    logic        illegal;

    typedef struct packed {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    logic pendKeep;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_issue #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .alu_C     (alu_C),
        .illegal   (illegal)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic ill, input logic keep);
        in_valid = 1'b1;
        instr    = ins;
        rs_data  = rs;
        rt_data  = rt;
        pend     = '{c: c, a: a, b: b, ill: ill};
        pendKeep = keep;
    endtask

    // Sample the handshakes just before the coming edge, then advance to the next negedge.
    task automatic step();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("spuriousOut", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("outC", {28'd0, alu_C}, {28'd0, e.c});
                checkOutput("outA", alu_A, e.a);
                checkOutput("outB", alu_B, e.b);
                checkOutput("outIllegal", {31'd0, illegal}, {31'd0, e.ill});
            end
        end
        if (in_valid && in_ready && pendKeep) begin
            sb.push_back(pend);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        rs_data   = '0;
        rt_data   = '0;
        pend      = '0;
        pendKeep  = 1'b0;

        step();
        step();
        checkOutput("rstInReady", {31'd0, in_ready}, 32'd0);
        checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstA", alu_A, 32'd0);
        checkOutput("rstB", alu_B, 32'd0);
        checkOutput("rstC", {28'd0, alu_C}, 32'd0);
        checkOutput("rstIllegal", {31'd0, illegal}, 32'd0);
        rst = 1'b0;
        step();
        checkOutput("idleInReady", {31'd0, in_ready}, 32'd1);

        // add, one-cycle latency
        applyStimulus(32'h00221820, 32'd5, 32'd7, 4'b0010, 32'd5, 32'd7, 1'b0, 1'b1);
        step();
        checkOutput("addLatency", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();

        // srl, lui, addi back to back
        applyStimulus(32'h00031102, 32'd0, 32'h80, 4'b1001, 32'h80, 32'd4, 1'b0, 1'b1);
        step();
        applyStimulus(32'h3C011234, 32'hDEAD, 32'hBEEF, 4'b1010, 32'd0, 32'h00001234, 1'b0, 1'b1);
        step();
        checkOutput("b2bInReady", {31'd0, in_ready}, 32'd1);
        applyStimulus(32'h2022FFFF, 32'd10, 32'd3, 4'b0010, 32'd10, 32'hFFFFFFFF, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        checkOutput("drainEmpty", {31'd0, out_valid}, 32'd0);

        // mul stretched over MUL_CYCLES
        applyStimulus(32'h70221802, 32'd6, 32'd7, 4'b1000, 32'd6, 32'd7, 1'b0, 1'b1);
        step();
        checkOutput("mulWait1Ready", {31'd0, in_ready}, 32'd0);
        checkOutput("mulWait1Valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(32'h00221820, 32'd1, 32'd2, 4'b0010, 32'd1, 32'd2, 1'b0, 1'b1);
        step();
        checkOutput("mulWait2Ready", {31'd0, in_ready}, 32'd0);
        checkOutput("mulWait2Valid", {31'd0, out_valid}, 32'd0);
        step();
        checkOutput("mulDoneValid", {31'd0, out_valid}, 32'd1);
        step();

        // backpressure holds add, then sub accepted with no bubble
        applyStimulus(32'h00221822, 32'd9, 32'd4, 4'b0110, 32'd9, 32'd4, 1'b0, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("holdValid", {31'd0, out_valid}, 32'd1);
            checkOutput("holdInReady", {31'd0, in_ready}, 32'd0);
            checkOutput("holdA", alu_A, 32'd1);
            checkOutput("holdB", alu_B, 32'd2);
            checkOutput("holdC", {28'd0, alu_C}, 32'h2);
        end
        out_ready = 1'b1;
        step();
        checkOutput("noBubbleValid", {31'd0, out_valid}, 32'd1);
        checkOutput("noBubbleA", alu_A, 32'd9);
        in_valid = 1'b0;
        step();

        // illegal opcode
        applyStimulus(32'hFC000000, 32'd3, 32'd4, 4'b0000, 32'd0, 32'd0, 1'b1, TRAP);
        step();
        in_valid = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        checkOutput("trapValid", {31'd0, out_valid}, 32'd1);
        checkOutput("trapIllegal", {31'd0, illegal}, 32'd1);
        checkOutput("trapC", {28'd0, alu_C}, 32'd0);
        step();
`else
        checkOutput("dropValid", {31'd0, out_valid}, 32'd0);
        checkOutput("dropInReady", {31'd0, in_ready}, 32'd1);
        step();
        checkOutput("dropValid2", {31'd0, out_valid}, 32'd0);
`endif

        // beq, lw, sw burst
        applyStimulus(32'h10220005, 32'h11, 32'h22, 4'b0110, 32'h11, 32'h22, 1'b0, 1'b1);
        step();
        applyStimulus(32'h8C220010, 32'h100, 32'd0, 4'b0010, 32'h100, 32'h10, 1'b0, 1'b1);
        step();
        applyStimulus(32'hAC22FFF0, 32'h200, 32'd0, 4'b0010, 32'h200, 32'hFFFFFFF0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        checkOutput("burstEmpty", {31'd0, out_valid}, 32'd0);

        // reset during MUL_WAIT drops the mul
        applyStimulus(32'h70221802, 32'd6, 32'd7, 4'b1000, 32'd6, 32'd7, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        checkOutput("killWaitValid", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        step();
        checkOutput("killInReady", {31'd0, in_ready}, 32'd0);
        checkOutput("killValid", {31'd0, out_valid}, 32'd0);
        checkOutput("killA", alu_A, 32'd0);
        checkOutput("killB", alu_B, 32'd0);
        checkOutput("killC", {28'd0, alu_C}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("killNeverOut", {31'd0, out_valid}, 32'd0);
        end
        checkOutput("postKillInReady", {31'd0, in_ready}, 32'd1);
        checkOutput("sbDrained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Registered ALU issue stage for the MIPS datapath. It accepts one instruction per handshake together with its register operands and decodes it into the ALU's `alu_C` control code and `alu_A`/`alu_B` operands. It holds those values stable for the ALU for as long as downstream needs them. It also stretches multiply issue over a programmable number of cycles, so the combinational `A * B` path can be constrained as a multicycle path.

## Interface
Parameters:
- `MUL_CYCLES`, default 3: cycles from accepting a mul to `out_valid`; legal range 1–15.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: upstream presents `instr`, `rs_data` and `rt_data`.
- `in_ready`, out, 1: stage can accept this cycle.
- `instr`, in, 32: MIPS instruction word.
- `rs_data`, in, 32: register file value for rs.
- `rt_data`, in, 32: register file value for rt.
- `out_valid`, out, 1: `alu_A`, `alu_B`, `alu_C` and `illegal` are valid.
- `out_ready`, in, 1: downstream consumes the current output.
- `alu_A`, out, 32: ALU operand A.
- `alu_B`, out, 32: ALU operand B.
- `alu_C`, out, 4: ALU control code.
- `illegal`, out, 1: the instruction is unsupported (only with the trap macro).

## Operation
Decode table (opcode is `instr[31:26]`, funct is `instr[5:0]`):
- opcode 0x00, funct 0x20 (add): C=0010, A=rs, B=rt.
- opcode 0x00, funct 0x22 (sub): C=0110, A=rs, B=rt.
- opcode 0x00, funct 0x02 (srl): C=1001, A=rt, B=zero-extended `instr[10:6]`.
- opcode 0x1C, funct 0x02 (mul): C=1000, A=rs, B=rt.
- opcode 0x0F (lui): C=1010, A=0, B=zero-extended `instr[15:0]`.
- opcode 0x08 (addi), 0x23 (lw), 0x2B (sw): C=0010, A=rs, B=sign-extended `instr[15:0]`.
- opcode 0x04 (beq): C=0110, A=rs, B=rt.
- Anything else is illegal: C=0000, A=0, B=0.

States:
- EMPTY: `in_ready`=1. On accept, go to MUL_WAIT if the instruction is mul and `MUL_CYCLES`>1, otherwise go to FULL.
- MUL_WAIT: `in_ready`=0 and `out_valid`=0. A down-counter is loaded with `MUL_CYCLES`-1 on accept and decrements every cycle. Go to FULL when it reaches 1, so `out_valid` rises exactly `MUL_CYCLES` cycles after accept.
- FULL: `out_valid`=1 and `in_ready`=`out_ready`. If `out_valid` && `out_ready` && `in_valid`, accept back-to-back and follow the EMPTY rules for the next state. If only `out_ready`, go to EMPTY. Otherwise stay and hold all outputs stable.

General rules:
- Outputs are registered and load only on accept (accept = `in_valid` && `in_ready`).
- `alu_A`, `alu_B` and `alu_C` never change while `out_valid`=1 && `out_ready`=0.
- `in_ready` is 0 whenever `rst`=1.

## Timing
- Reset: state=EMPTY, `out_valid`=0, `alu_A`=0, `alu_B`=0, `alu_C`=0000, `illegal`=0, counter=0.
- Reset mid-operation, including MUL_WAIT, drops the held instruction; it is never output.
- Latency for non-mul: accept at edge N, `out_valid`=1 after edge N.
- Latency for mul: `out_valid`=1 `MUL_CYCLES` edges after accept.
- Throughput is 1 per cycle for non-mul with `out_ready` held at 1. A mul blocks the stage for `MUL_CYCLES` cycles.
- Simultaneous consume and accept in FULL: there is no bubble; the new values appear on the next edge.
- `MUL_CYCLES`=1: mul behaves like any other instruction and goes directly to FULL.

## Configuration
Macro `ALU_ISSUE_ILLEGAL_TRAP_EN`.
- Defined: illegal instructions go to FULL with `illegal`=1, C=0000 and A=B=0, and are handshaked like any other instruction.
- Undefined: illegal instructions are accepted and silently dropped (the stage stays in or returns to EMPTY, and no `out_valid` pulse occurs). The `illegal` port exists but is tied to 0.

## Structure
- Shared package `alu_pkg` holds:
  - the ALU code constants ALU_ADD=0010, ALU_SUB=0110, ALU_MUL=1000, ALU_SRL=1001, ALU_LUI=1010;
  - the opcode and funct constants;
  - the state enum (EMPTY, MUL_WAIT, FULL).
- One sub-module, `alu_decode`, is purely combinational: `instr`, `rs_data`, `rt_data` → `alu_C`, A, B, `is_mul`, `illegal`. `alu_issue` keeps the registers, counter and FSM.

## Test plan
- add: `instr`=0x00221820, rs=5, rt=7 → one cycle later `out_valid`=1, C=0010, A=5, B=7.
- srl and lui: 0x00031102 with rt=0x80 → C=1001, A=0x80, B=4. Then 0x3C011234 → C=1010, A=0, B=0x00001234.
- addi sign-extension: 0x2022FFFF with rs=10 → C=0010, A=10, B=0xFFFFFFFF.
- mul with `MUL_CYCLES`=3: 0x70221802, rs=6, rt=7 → `in_ready`=0 and `out_valid`=0 for 2 cycles, then `out_valid`=1, C=1000, A=6, B=7.
- Backpressure: `out_ready`=0 for 4 cycles while FULL → outputs are unchanged and `in_ready`=0. Raising `out_ready` with `in_valid`=1 accepts the next instruction with no bubble.
- Illegal and reset: 0xFC000000 → with the macro, `illegal`=1 and C=0000; without it, no `out_valid`. Asserting `rst` during MUL_WAIT → all outputs 0 the next cycle and the mul is never output.
